// File: rtl/playseq_condicionador_entradas_pkg.sv
// Shared state codes, default parameters and bit-count helper for the jogo_playseq input conditioner.
// No datapath, no latency, no flow control.
package playseq_condicionador_entradas_pkg;

    typedef enum logic [1:0] {
        LIVRE     = 2'd0,
        UM_BOTAO  = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

    localparam int N_BOTOES_PADRAO        = 4;
    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
    localparam int CONT_W_PADRAO          = 16;

    // Vectors wider than 32 bits are truncated; the button count stays far below that.
    function automatic int unsigned contar_uns(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/playseq_condicionador_entradas_debounce_canal.sv
// One button channel: 2-FF synchroniser then a stability counter that only accepts a level held DEBOUNCE_CICLOS samples.
// Latency DEBOUNCE_CICLOS+2 edges from a clean raw edge; no backpressure, input is free-running.
module playseq_condicionador_entradas_debounce_canal #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CONT_W          = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada_raw,
    output logic estavel
);

    localparam logic [CONT_W-1:0] CONT_LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

    logic              r_sinc1;
    logic              r_sinc2;
    logic              r_estavel;
    logic [CONT_W-1:0] r_cont;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc1   <= 1'b0;
            r_sinc2   <= 1'b0;
            r_estavel <= 1'b0;
            r_cont    <= '0;
        end else begin
            r_sinc1 <= entrada_raw;
            r_sinc2 <= r_sinc1;
            // Any sample agreeing with the accepted level restarts the count, so glitches never accumulate.
            if (r_sinc2 == r_estavel) begin
                r_cont <= '0;
            end else if (r_cont == CONT_LIMITE) begin
                r_estavel <= r_sinc2;
                r_cont    <= '0;
            end else begin
                r_cont <= r_cont + CONT_W'(1);
            end
        end
    end

    assign estavel = r_estavel;

endmodule

// File: rtl/playseq_condicionador_entradas.sv
// Debounces buttons + start, lets through only single-button plays and blocks multi-button presses until all released.
// Raw press to botoes/jogada_pulso/jogar: DEBOUNCE_CICLOS+3 cycles; no backpressure, downstream must sample every cycle.
module playseq_condicionador_entradas
    import playseq_condicionador_entradas_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int CONT_W          = CONT_W_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                jogar_raw,
    output logic [N_BOTOES-1:0] botoes,
    output logic                jogar,
    output logic                jogada_pulso,
    output logic                erro_multiplo,
    output logic [1:0]          db_estado
);

    logic [N_BOTOES:0]   w_raw;
    logic [N_BOTOES:0]   w_estavel;
    logic [N_BOTOES-1:0] w_s;
    logic                w_estavel_jogar;
    int unsigned         w_qtd;

    estado_t             r_estado;
    estado_t             w_prox;
    logic [N_BOTOES-1:0] w_botoes_prox;
    logic                w_pulso_prox;
    logic                w_erro_prox;

    logic [N_BOTOES-1:0] r_botoes;
    logic                r_jogada_pulso;
    logic                r_erro;
    logic                r_jogar_ant;
    logic                r_jogar;

    // Channel N_BOTOES is the start button; the others are the play buttons.
    assign w_raw = {jogar_raw, botoes_raw};

    for (genvar g = 0; g <= N_BOTOES; g++) begin : g_canal
        playseq_condicionador_entradas_debounce_canal #(
            .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
            .CONT_W          (CONT_W)
        ) u_canal (
            .clock       (clock),
            .reset       (reset),
            .entrada_raw (w_raw[g]),
            .estavel     (w_estavel[g])
        );
    end

    assign w_s             = w_estavel[N_BOTOES-1:0];
    assign w_estavel_jogar = w_estavel[N_BOTOES];
    assign w_qtd           = contar_uns(32'(w_s));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= LIVRE;
        end else begin
            r_estado <= w_prox;
        end
    end

    // r_botoes holds the accepted one-hot while in UM_BOTAO, so it doubles as the reference press.
    always_comb begin
        w_prox = LIVRE;
        case (r_estado)
            LIVRE: begin
                if (w_qtd == 0)      w_prox = LIVRE;
                else if (w_qtd == 1) w_prox = UM_BOTAO;
                else                 w_prox = BLOQUEADO;
            end
            UM_BOTAO: begin
                if (w_s == r_botoes) w_prox = UM_BOTAO;
                else if (w_qtd == 0) w_prox = LIVRE;
                else                 w_prox = BLOQUEADO;
            end
            BLOQUEADO: begin
                if (w_qtd == 0) w_prox = LIVRE;
                else            w_prox = BLOQUEADO;
            end
            default: w_prox = LIVRE;
        endcase
    end

    always_comb begin
        w_botoes_prox = '0;
        w_pulso_prox  = 1'b0;
        w_erro_prox   = 1'b0;
        if (w_prox == UM_BOTAO) begin
            w_botoes_prox = w_s;
        end
        if ((r_estado == LIVRE) && (w_prox == UM_BOTAO)) begin
            w_pulso_prox = 1'b1;
        end
        if (w_prox == BLOQUEADO) begin
            w_erro_prox = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_botoes       <= '0;
            r_jogada_pulso <= 1'b0;
            r_erro         <= 1'b0;
            r_jogar_ant    <= 1'b0;
            r_jogar        <= 1'b0;
        end else begin
            r_botoes       <= w_botoes_prox;
            r_jogada_pulso <= w_pulso_prox;
            r_erro         <= w_erro_prox;
            r_jogar_ant    <= w_estavel_jogar;
            r_jogar        <= w_estavel_jogar & ~r_jogar_ant;
        end
    end

    assign botoes        = r_botoes;
    assign jogada_pulso  = r_jogada_pulso;
    assign erro_multiplo = r_erro;
    assign jogar         = r_jogar;
    assign db_estado     = r_estado;

endmodule
